// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage sign-magnitude fixed-point add/subtract with valid/ready handshake.
// Build option: define FXP_ADDSUB_SATURATE_EN to saturate the magnitude on overflow instead of wrapping.
module fixed_point_addsub_pipe #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int M = N - 1;

  // Q only names the binary point; both operands share it, so it never reaches the datapath.
  if (N < 4 || Q > N - 2) begin : g_bad_params
    $error("fixed_point_addsub_pipe: need N >= 4 and Q <= N-2");
  end

  logic         s1_valid_q, s1_valid_d;
  logic [M-1:0] ma_q, ma_d;
  logic [M-1:0] mb_q, mb_d;
  logic         a_sign_q, a_sign_d;
  logic         eff_sb_q, eff_sb_d;
  logic         same_q, same_d;
  logic         a_ge_q, a_ge_d;

  logic         s2_valid_q, s2_valid_d;
  logic [N-1:0] c_q, c_d;
  logic         ovf_q, ovf_d;

  logic         s2_load;
  logic         s1_load;

  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign c         = c_q;
  assign ovf       = ovf_q;

  // Stage 1: split into magnitudes and classify the operation.
  always_comb begin
    s1_valid_d = s1_valid_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    a_sign_d   = a_sign_q;
    eff_sb_d   = eff_sb_q;
    same_d     = same_q;
    a_ge_d     = a_ge_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        ma_d     = a[M-1:0];
        mb_d     = b[M-1:0];
        a_sign_d = a[N-1];
        eff_sb_d = b[N-1] ^ sub;
        same_d   = (a[N-1] == (b[N-1] ^ sub));
        a_ge_d   = (a[M-1:0] >= b[M-1:0]);
      end
    end
  end

  logic [N-1:0] sum_w;
  logic [M-1:0] mag_w;
  logic         sign_w;
  logic         ovf_w;

  // Stage 2 arithmetic on the registered magnitudes.
  always_comb begin
    sum_w  = {1'b0, ma_q} + {1'b0, mb_q};
    mag_w  = '0;
    sign_w = a_sign_q;
    ovf_w  = 1'b0;
    if (same_q) begin
      ovf_w = sum_w[N-1];
`ifdef FXP_ADDSUB_SATURATE_EN
      mag_w = sum_w[N-1] ? {M{1'b1}} : sum_w[M-1:0];
`else
      mag_w = sum_w[M-1:0];
`endif
    end else if (a_ge_q) begin
      mag_w = ma_q - mb_q;
    end else begin
      mag_w  = mb_q - ma_q;
      sign_w = eff_sb_q;
    end
    // Never emit negative zero, including a wrapped overflow that lands on zero.
    if (mag_w == '0) begin
      sign_w = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
    ovf_d      = ovf_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        c_d   = {sign_w, mag_w};
        ovf_d = ovf_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      a_sign_q   <= 1'b0;
      eff_sb_q   <= 1'b0;
      same_q     <= 1'b0;
      a_ge_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      a_sign_q   <= a_sign_d;
      eff_sb_q   <= eff_sb_d;
      same_q     <= same_d;
      a_ge_q     <= a_ge_d;
      s2_valid_q <= s2_valid_d;
      c_q        <= c_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Randomized and directed check of fixed_point_addsub_pipe against a signed-integer reference model.
module tb_fixed_point_addsub_pipe;

  localparam int N = 32;
  localparam int Q = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  logic [N:0] exp_q[$];
  logic       acc_flag;
  logic       pop_flag;

  fixed_point_addsub_pipe #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  // Reference: interpret as signed integers, add, then map back to sign-magnitude.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic s);
    longint mx, my, vx, vy, res, mag, lim;
    logic   neg, of;
    logic [N-2:0] m;
    mx  = longint'(x[N-2:0]);
    my  = longint'(y[N-2:0]);
    vx  = x[N-1] ? -mx : mx;
    vy  = y[N-1] ? -my : my;
    res = s ? vx - vy : vx + vy;
    neg = (res < 0);
    mag = neg ? -res : res;
    lim = longint'(1) << (N - 1);
    of  = (mag >= lim);
    if (of) begin
`ifdef FXP_ADDSUB_SATURATE_EN
      mag = lim - 1;
`else
      mag = mag - lim;
`endif
    end
    m = mag[N-2:0];
    return {of, neg && (m != '0), m};
  endfunction

  // One clock: drive at the falling edge, observe 1 time unit later, before the rising edge.
  task automatic step(input logic iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                      input logic is, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sub       = is;
    out_ready = ordy;
    #1;
    acc_flag = in_valid && in_ready;
    pop_flag = out_valid && out_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("c", 64'(c), 64'(exp_q[0][N-1:0]));
        chk("ovf", 64'(ovf), 64'(exp_q[0][N]));
      end
    end
    if (pop_flag && exp_q.size() > 0) begin
      $display("out  c=%h ovf=%0d", c, ovf);
      void'(exp_q.pop_front());
    end
    if (acc_flag) begin
      $display("in   a=%h b=%h sub=%0d", ia, ib, is);
      exp_q.push_back(model(ia, ib, is));
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Present one operation on an idle pipe; the result must appear exactly two cycles later.
  task automatic directed(input string tag, input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic is, input logic [N-1:0] ec, input logic eo);
    step(1'b1, ia, ib, is, 1'b1);
    chk({tag, "_accept"}, 64'(acc_flag), 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_c"}, 64'(c), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    drain(10);
  endtask

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = {1'($urandom_range(0, 1)), {(N-1){1'b1}}};
      1:       v = {1'($urandom_range(0, 1)), {(N-1){1'b0}}};
      2:       v = N'($urandom_range(0, 3)) | {1'($urandom_range(0, 1)), {(N-1){1'b0}}};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  logic [N-1:0] pa[4];
  logic [N-1:0] pb[4];

  initial begin
    int idx, accepts, pops;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    directed("add", 32'h0000_8000, 32'h0000_4000, 1'b0, 32'h0000_C000, 1'b0);
    directed("mixed", 32'h0000_4000, 32'h8000_8000, 1'b0, 32'h8000_4000, 1'b0);
    directed("zero_sub", 32'h0000_8000, 32'h0000_8000, 1'b1, 32'h0000_0000, 1'b0);
    directed("neg_zero", 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
`ifdef FXP_ADDSUB_SATURATE_EN
    directed("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1);
    directed("ovf_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1);
`else
    directed("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    directed("ovf_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1);
`endif

    // Backpressure: four pairs offered while the consumer stalls.
    for (int i = 0; i < 4; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    idx = 0;
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pa[idx], pb[idx], 1'b0, 1'b0);
      if (acc_flag) begin
        idx++;
        accepts++;
      end
    end
    chk("bp_accepts", 64'(accepts), 64'd2);
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      step(idx < 4, pa[idx % 4], pb[idx % 4], 1'b0, 1'b1);
      if (acc_flag) idx++;
      if (pop_flag) pops++;
    end
    chk("bp_pops_per_cycle", 64'(pops), 64'd4);
    drain(10);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 7));
    end
    drain(20);

    // Full throughput: no bubbles while the consumer is always ready.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b1);
      chk("full_rate_in_ready", 64'(in_ready), 64'd1);
    end
    drain(10);

    // Reset with both stages occupied.
    step(1'b1, 32'h0000_8000, 32'h0000_4000, 1'b0, 1'b0);
    step(1'b1, 32'h0000_8000, 32'h0000_4000, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_c", 64'(c), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
